// File: rtl/mux_rr_arb.sv
// mux_rr_arb: round-robin owner arbiter for a shared 4:1 mux with an
// active-low enable. One requester owns the mux at a time. Every change of
// ownership passes through a one-cycle GAP so the old channel is released
// before the new one is enabled. An owner is forced off after MAX_HOLD
// consecutive cycles, but only if another requester is waiting.
//
// Ports:
//   CLK    - clock, rising edge
//   RST_N  - asynchronous active-low reset
//   REQ    - per-channel level request (bit n asks for mux channel n)
//   Y      - shared mux output (1 while G=1)
//   GNT    - one-hot grant, zero when there is no owner
//   G      - active-low mux enable, 0 only while granting
//   C      - mux select; the bit order is swapped (C[0]=idx[1], C[1]=idx[0])
//   BUSY   - high in GRANT and GAP
//   Y_Q    - registered sample of Y
//   Y_VLD  - Y_Q was sampled while granting
module mux_rr_arb #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] REQ,
  input  logic       Y,
  output logic [3:0] GNT,
  output logic       G,
  output logic [1:0] C,
  output logic       BUSY,
  output logic       Y_Q,
  output logic       Y_VLD
);

  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned HC_W  = 4;
  localparam logic [HC_W-1:0] HC_MAX = HC_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_GAP   = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [HC_W-1:0]    hc_q, hc_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic               g_q, g_d;
  logic [1:0]         c_q, c_d;
  logic               busy_q, busy_d;
  logic               y_q, y_vld_q;
  logic               others_req;

  // First requester found when searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  // The loop runs from the farthest offset down, so the nearest one wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] req,
                                                input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] win;
    win = ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = ptr + IDX_W'(i);
      if (req[idx]) win = idx;
    end
    return win;
  endfunction

  // Next state, pointer, hold counter, and the output values for the next cycle.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hc_d    = hc_q;

    others_req = |(REQ & ~(NREQ'(1) << owner_q));

    case (state_q)
      ST_IDLE: begin
        if (|REQ) begin
          state_d = ST_GRANT;
          owner_d = rr_pick(REQ, ptr_q);
          hc_d    = '0;
        end
      end
      ST_GRANT: begin
        if (!REQ[owner_q] || ((hc_q == HC_MAX) && others_req)) begin
          state_d = ST_GAP;
        end else if (hc_q != HC_MAX) begin
          hc_d = hc_q + HC_W'(1);
        end
      end
      ST_GAP: begin
        // The pointer moves past the old owner, so a re-request from the old
        // owner has the lowest priority.
        ptr_d = owner_q + IDX_W'(1);
        if (|REQ) begin
          state_d = ST_GRANT;
          owner_d = rr_pick(REQ, ptr_d);
          hc_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    gnt_d  = (state_d == ST_GRANT) ? (NREQ'(1) << owner_d) : '0;
    g_d    = (state_d != ST_GRANT);
    busy_d = (state_d != ST_IDLE);
    // C changes only when a grant starts. It keeps the last owner through GAP and IDLE.
    c_d    = (state_d == ST_GRANT) ? {owner_d[0], owner_d[1]} : c_q;
  end

  // State and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      hc_q    <= '0;
      gnt_q   <= '0;
      g_q     <= 1'b1;
      c_q     <= '0;
      busy_q  <= 1'b0;
      y_q     <= 1'b1;
      y_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hc_q    <= hc_d;
      gnt_q   <= gnt_d;
      g_q     <= g_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      y_q     <= Y;
      y_vld_q <= (state_q == ST_GRANT);
    end
  end

  assign GNT   = gnt_q;
  assign G     = g_q;
  assign C     = c_q;
  assign BUSY  = busy_q;
  assign Y_Q   = y_q;
  assign Y_VLD = y_vld_q;

endmodule

// File: tb/tb_mux_rr_arb.sv
// tb_mux_rr_arb: directed and randomized test of mux_rr_arb against a
// behavioural ownership model. The bench also models the external 4:1 mux
// that drives Y.
module tb_mux_rr_arb;

  localparam int MAX_HOLD = 8;

  logic       CLK;
  logic       RST_N;
  logic [3:0] REQ;
  logic [3:0] X;
  logic       Y;
  logic [3:0] GNT;
  logic       G;
  logic [1:0] C;
  logic       BUSY;
  logic       Y_Q;
  logic       Y_VLD;

  int n_checks = 0;
  int n_errors = 0;

  mux_rr_arb #(.MAX_HOLD(MAX_HOLD)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .REQ   (REQ),
    .Y     (Y),
    .GNT   (GNT),
    .G     (G),
    .C     (C),
    .BUSY  (BUSY),
    .Y_Q   (Y_Q),
    .Y_VLD (Y_VLD)
  );

  // External mux: the select bits are swapped, and the output is high while disabled.
  logic [1:0] mux_idx;
  assign mux_idx = {C[0], C[1]};
  assign Y = G ? 1'b1 : X[mux_idx];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the mux, whether a release gap is in
  // progress, how long the current owner has held, and where rotation resumes.
  int  m_owner;
  int  m_cidx;
  int  m_hc;
  int  m_ptr;
  int  m_new;
  bit  m_granting;
  bit  m_gap;
  bit  m_yq;
  bit  m_yvld;
  bit  m_others;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_owner = 0; m_cidx = 0; m_hc = 0; m_ptr = 0;
      m_granting = 0; m_gap = 0; m_yq = 1; m_yvld = 0;
    end else begin
      m_yq   = m_granting ? X[m_owner] : 1'b1;
      m_yvld = m_granting;
      m_new  = -1;
      if (m_granting) begin
        m_others = (REQ & ~(4'b0001 << m_owner)) != 4'b0;
        if (!REQ[m_owner] || (m_hc == MAX_HOLD - 1 && m_others)) begin
          m_granting = 0;
          m_gap      = 1;
        end else if (m_hc < MAX_HOLD - 1) begin
          m_hc++;
        end
      end else if (m_gap) begin
        m_gap = 0;
        m_ptr = (m_owner + 1) % 4;
        m_new = pick(REQ, m_ptr);
      end else begin
        m_new = pick(REQ, m_ptr);
      end
      if (m_new >= 0) begin
        m_owner = m_new; m_cidx = m_new; m_hc = 0; m_granting = 1;
      end
    end
  end

  function automatic logic [9:0] exp_vec();
    logic [1:0] cv;
    logic [3:0] gv;
    cv = 2'(m_cidx);
    gv = m_granting ? 4'(1 << m_owner) : 4'b0;
    return {gv, ~m_granting, cv[0], cv[1], m_granting | m_gap, m_yq, m_yvld};
  endfunction

  // Per-cycle comparison against the model, plus structural invariants.
  always @(negedge CLK) begin
    check("outputs{GNT,G,C,BUSY,Y_Q,Y_VLD}", 16'({GNT, G, C, BUSY, Y_Q, Y_VLD}), 16'(exp_vec()));
    check("gnt_onehot0", 16'($onehot0(GNT)), 16'(1));
    check("g_iff_no_gnt", 16'(G), 16'(GNT == 4'b0));
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    REQ = 4'b0;
    @(posedge CLK);
    #2 RST_N = 1'b0;
    @(posedge CLK);
    #1 RST_N = 1'b1;
  endtask

  logic [3:0] flip;

  initial begin
    RST_N = 1'b1;
    REQ   = 4'b0;
    X     = 4'b0;
    #1 RST_N = 1'b0;
    #1;
    check("reset_vec", 16'({GNT, G, C, BUSY, Y_Q, Y_VLD}), 16'(10'b0000_1_00_0_1_0));
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;

    // A single request is granted one edge later.
    REQ = 4'b0100;
    step(1);
    check("first_gnt", 16'(GNT), 16'(4'b0100));
    check("first_g", 16'(G), 16'(0));
    check("first_c", 16'(C), 16'(2'b01));
    check("first_busy", 16'(BUSY), 16'(1));
    REQ = 4'b0;
    step(3);

    // All channels requesting: ch0..3 then ch0, 8 cycles each, gap between.
    do_reset();
    REQ = 4'hF;
    for (int k = 0; k < 44; k++) begin
      step(1);
      check("rr_seq_gnt", 16'(GNT), (k % 9 < 8) ? 16'(1 << ((k / 9) % 4)) : 16'(0));
      check("rr_seq_g", 16'(G), 16'(k % 9 == 8));
    end

    // A sole requester keeps the grant with no forced gap.
    do_reset();
    REQ = 4'b0010;
    for (int k = 0; k < 20; k++) begin
      step(1);
      check("sole_hold_gnt", 16'(GNT), 16'(4'b0010));
    end

    // The owner releases while ch0 waits: a gap, then ch0 is granted.
    do_reset();
    REQ = 4'b0100;
    step(1);
    REQ = 4'b0101;
    step(2);
    check("owner2_held", 16'(GNT), 16'(4'b0100));
    REQ = 4'b0001;
    step(1);
    check("release_gap_gnt", 16'(GNT), 16'(0));
    check("release_gap_g", 16'(G), 16'(1));
    check("release_gap_c", 16'(C), 16'(2'b01));
    step(1);
    check("after_gap_gnt", 16'(GNT), 16'(4'b0001));
    check("after_gap_c", 16'(C), 16'(2'b00));

    // Mux data path: ch3 selected, X[3]=0.
    do_reset();
    X   = 4'b0111;
    REQ = 4'b1000;
    step(1);
    check("ch3_y", 16'(Y), 16'(0));
    step(1);
    check("ch3_yq", 16'(Y_Q), 16'(0));
    check("ch3_yvld", 16'(Y_VLD), 16'(1));
    REQ = 4'b0;
    step(3);
    check("idle_yq", 16'(Y_Q), 16'(1));
    check("idle_yvld", 16'(Y_VLD), 16'(0));

    // Asynchronous reset in the middle of a grant.
    do_reset();
    REQ = 4'b0100;
    step(2);
    #1 RST_N = 1'b0;
    #1;
    check("async_rst_g", 16'(G), 16'(1));
    check("async_rst_gnt", 16'(GNT), 16'(0));
    check("async_rst_busy", 16'(BUSY), 16'(0));
    #1 RST_N = 1'b1;
    REQ = 4'b1000;
    @(posedge CLK);
    #1;
    check("post_rst_gnt", 16'(GNT), 16'(4'b1000));
    check("post_rst_g", 16'(G), 16'(0));

    // Random requests that change slowly, random mux data, occasional resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 5) == 0);
      REQ = REQ ^ flip;
      X   = 4'($urandom);
      if (cyc % 1000 == 999) begin
        #1 RST_N = 1'b0;
        #2 RST_N = 1'b1;
      end
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/mux_rr_arb.md
MUX_RR_ARB -- requirements
Module: mux_rr_arb

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive grant cycles before forced rotation when another requester waits; legal range 2..15.
REQ-002 Port: CLK  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: RST_N  input  1  asynchronous, active-low reset.
REQ-004 Port: REQ  input  4  per-requester level request; bit n requests mux channel n.
REQ-005 Port: Y  input  1  output of the shared 4:1 mux; equals the selected X bit while G=0, and 1 while G=1.
REQ-006 Port: GNT  output  4  one-hot grant; all-zero when no owner.
REQ-007 Port: G  output  1  active-low mux enable; 0 only in GRANT.
REQ-008 Port: C  output  2  mux select in mux encoding: C[0] = owner index bit 1, C[1] = owner index bit 0.
REQ-009 Port: BUSY  output  1  1 in GRANT or GAP.
REQ-010 Port: Y_Q  output  1  registered sample of Y.
REQ-011 Port: Y_VLD  output  1  1 when Y_Q holds a sample taken during GRANT.

Function
REQ-012 Registered FSM with states IDLE, GRANT, GAP; all outputs driven from registers, none combinational from REQ.
REQ-013 Round-robin pointer PTR (2 bits): winner = first n with REQ[n]=1, searching PTR, PTR+1, PTR+2, PTR+3 mod 4.
REQ-014 IDLE: G=1, GNT=0; if any REQ bit set, next state GRANT with the REQ-013 winner as owner; otherwise stay in IDLE.
REQ-015 GRANT: G=0, GNT[owner]=1, C encodes owner per REQ-008; hold counter HC resets to 0 on entry and increments each GRANT cycle, saturating at MAX_HOLD-1.
REQ-016 GRANT exit: when REQ[owner]=0, or when HC=MAX_HOLD-1 and any other REQ bit=1 -> GAP; otherwise stay in GRANT.
REQ-017 Sole requester at HC=MAX_HOLD-1 keeps the grant indefinitely; HC stays saturated.
REQ-018 GAP: exactly one cycle; G=1, GNT=0, C holds the previous owner's value (break-before-make); PTR <= owner+1 mod 4.
REQ-019 GAP exit: if any REQ bit set, next state GRANT with the winner computed from the updated PTR; otherwise IDLE.
REQ-020 The previous owner's re-request in GAP is granted only if no other requester is pending (lowest priority after rotation).
REQ-021 Grant latency: REQ rising in IDLE -> GNT/G asserted on the next edge (1 cycle).
REQ-022 Y_Q <= Y every cycle; Y_VLD <= 1 when the sampled cycle was in GRANT, else 0.
REQ-023 GNT is never multi-hot; G=0 iff GNT!=0; state encodings outside IDLE/GRANT/GAP recover to IDLE on the next edge.
REQ-024 REQ changes to non-owner bits during GRANT have no effect until HC saturates or the owner releases.

Reset
REQ-025 RST_N=0 immediately, independent of CLK: state=IDLE, PTR=0, HC=0, GNT=0, G=1, C=00, BUSY=0, Y_Q=1, Y_VLD=0.
REQ-026 Reset asserted mid-GRANT releases the mux (G=1) in the same instant; the first grant after reset release is arbitrated from PTR=0.
REQ-027 Deassertion of RST_N is synchronous to CLK; the first state change occurs no earlier than the first rising edge after deassertion.

Verification
REQ-028 Reset, then REQ=0100 -> next edge GNT=0100, G=0, C=01 (mux encoding), BUSY=1.
REQ-029 REQ=1111 held, MAX_HOLD=8 -> grants ch0,1,2,3,0 in order, 8 GRANT cycles each, one GAP cycle (G=1, GNT=0) between each.
REQ-030 REQ=0010 only, held 20 cycles -> GNT=0010 for all 20 cycles, no GAP, HC saturated at 7.
REQ-031 Owner ch2 drops REQ after 3 cycles while REQ[0]=1 -> GAP next cycle, then GNT=0001, PTR=3 during the ch0 grant.
REQ-032 During ch3 GRANT with X[3]=0 -> Y=0, Y_Q=0 and Y_VLD=1 one cycle later; in IDLE Y_Q=1, Y_VLD=0.
REQ-033 RST_N pulsed low mid-GRANT between edges -> G=1, GNT=0 without a clock edge; after release REQ=1000 -> GNT=1000 on the next edge.
